// File: rtl/regfile_pkg.sv
// Shared defaults for the banked register file.
package regfile_pkg;
  localparam int unsigned RF_WIDTH  = 16;
  localparam int unsigned RF_NREGS  = 16;
  localparam int unsigned RF_NBANKS = 2;
endpackage : regfile_pkg

// File: rtl/regfile_bank.sv
// One register bank: async clear, one write port, two combinational read ports, r0 hardwired to 0.
module regfile_bank #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 16,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  logic [WIDTH-1:0] mem [NREGS];

  // Storage; writes to r0 are dropped so it stays 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule : regfile_bank

// File: rtl/regfile_banked.sv
// Multi-bank register file: bank-select counter, write steering, read mux and optional write bypass.
module regfile_banked
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = RF_WIDTH,
  parameter int unsigned NREGS  = RF_NREGS,
  parameter int unsigned NBANKS = RF_NBANKS,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW = $clog2(NREGS),
  localparam int unsigned BW = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic             bank_swap,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [BW-1:0]    active_bank
);

  logic [WIDTH-1:0] bank_rd1 [NBANKS];
  logic [WIDTH-1:0] bank_rd2 [NBANKS];
  logic [WIDTH-1:0] sel_rd1, sel_rd2;
  logic             wr_live;

  // Bank-select counter; a single bank never advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_bank <= '0;
    end else if (bank_swap && (NBANKS > 1)) begin
      active_bank <= (active_bank == BW'(NBANKS - 1)) ? '0 : active_bank + BW'(1);
    end
  end

  // Writes go to the bank active before any same-edge swap.
  for (genvar b = 0; b < NBANKS; b++) begin : gen_bank
    regfile_bank #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
    ) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (we3 && (active_bank == BW'(b))),
      .wa    (wa3),
      .wd    (wd3),
      .ra1   (ra1),
      .ra2   (ra2),
      .rd1   (bank_rd1[b]),
      .rd2   (bank_rd2[b])
    );
  end

  always_comb begin
    sel_rd1 = '0;
    sel_rd2 = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (active_bank == BW'(b)) begin
        sel_rd1 = bank_rd1[b];
        sel_rd2 = bank_rd2[b];
      end
    end
  end

  assign wr_live = (BYPASS != 0) && we3 && (wa3 != '0);

  // Forwarding, then r0 and reset force zero on top of everything.
  always_comb begin
    rd1 = sel_rd1;
    rd2 = sel_rd2;
    if (wr_live && (ra1 == wa3)) rd1 = wd3;
    if (wr_live && (ra2 == wa3)) rd2 = wd3;
    if (reset || (ra1 == '0)) rd1 = '0;
    if (reset || (ra2 == '0)) rd2 = '0;
  end

endmodule : regfile_banked

// File: tb/tb_regfile_banked.sv
// Self-checking bench: bypass and non-bypass instances against an array-based reference model.
module tb_regfile_banked;
  import regfile_pkg::*;

  localparam int unsigned WIDTH  = RF_WIDTH;
  localparam int unsigned NREGS  = RF_NREGS;
  localparam int unsigned NBANKS = RF_NBANKS;
  localparam int unsigned AW     = $clog2(NREGS);
  localparam int unsigned BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             we3;
  logic [AW-1:0]    wa3;
  logic [WIDTH-1:0] wd3;
  logic [AW-1:0]    ra1, ra2;
  logic             bank_swap;
  logic [WIDTH-1:0] rd1, rd2, nb_rd1, nb_rd2;
  logic [BW-1:0]    active_bank, nb_active_bank;

  int compared   = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] model [NBANKS][NREGS];
  int               model_bank;

  always #10 clk = ~clk;

  regfile_banked #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .bank_swap(bank_swap),
    .rd1(rd1), .rd2(rd2), .active_bank(active_bank)
  );

  regfile_banked #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .bank_swap(bank_swap),
    .rd1(nb_rd1), .rd2(nb_rd2), .active_bank(nb_active_bank)
  );

  task automatic drive(input logic p_we, input logic [AW-1:0] p_wa, input logic [WIDTH-1:0] p_wd,
                       input logic [AW-1:0] p_ra1, input logic [AW-1:0] p_ra2, input logic p_swap);
    we3 = p_we; wa3 = p_wa; wd3 = p_wd; ra1 = p_ra1; ra2 = p_ra2; bank_swap = p_swap;
    #2;
  endtask

  // Advance one edge and apply the architectural effect of the driven inputs to the model.
  task automatic commit();
    @(posedge clk);
    if (!reset) begin
      if (we3 && wa3 != '0) model[model_bank][wa3] = wd3;
      if (bank_swap) model_bank = (model_bank + 1) % NBANKS;
    end
    #1;
  endtask

  task automatic model_clear();
    for (int b = 0; b < NBANKS; b++)
      for (int r = 0; r < NREGS; r++) model[b][r] = '0;
    model_bank = 0;
  endtask

  function automatic logic [WIDTH-1:0] exp_rd(input logic [AW-1:0] ra, input bit byp);
    if (reset || ra == '0) return '0;
    if (byp && we3 && wa3 != '0 && ra == wa3) return wd3;
    return model[model_bank][ra];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    drive(1'b1, AW'(3), 16'hBEEF, AW'(3), AW'(3), 1'b1);
    @(posedge clk); #1;
    compared++;
    if (rd1 !== '0 || nb_rd1 !== '0) begin
      mismatched++;
      $display("FAIL reset_bypass_rd1: got %h/%h expected 0", rd1, nb_rd1);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    reset = 1'b0;
    #1;
    for (int a = 0; a < NREGS; a++) begin
      drive(1'b0, '0, '0, AW'(a), AW'(NREGS - 1 - a), 1'b0);
      compared++;
      if (rd1 !== '0 || rd2 !== '0 || nb_rd1 !== '0 || nb_rd2 !== '0 || active_bank !== '0) begin
        mismatched++;
        $display("FAIL reset_read a=%0d: got %h %h %h %h bank %0d expected 0", a, rd1, rd2, nb_rd1, nb_rd2, active_bank);
      end
    end
  endtask

  task automatic test_write_r0();
    drive(1'b1, AW'(5), 16'h1234, '0, '0, 1'b0);
    commit();
    drive(1'b1, AW'(0), 16'hFFFF, AW'(5), AW'(0), 1'b0);
    compared++;
    if (rd2 !== '0 || nb_rd2 !== '0) begin
      mismatched++;
      $display("FAIL r0_bypass: got %h/%h expected 0", rd2, nb_rd2);
    end
    commit();
    drive(1'b0, '0, '0, AW'(5), AW'(0), 1'b0);
    compared++;
    if (rd1 !== 16'h1234 || rd2 !== '0 || nb_rd1 !== 16'h1234 || nb_rd2 !== '0) begin
      mismatched++;
      $display("FAIL r5_r0: got %h %h %h %h expected 1234 0", rd1, rd2, nb_rd1, nb_rd2);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, AW'(3), 16'hBEEF, AW'(3), AW'(5), 1'b0);
    compared++;
    if (rd1 !== 16'hBEEF) begin
      mismatched++;
      $display("FAIL bypass_fwd: got %h expected beef", rd1);
    end
    compared++;
    if (nb_rd1 !== '0 || nb_rd2 !== 16'h1234 || rd2 !== 16'h1234) begin
      mismatched++;
      $display("FAIL nobypass_old: got %h %h %h expected 0 1234 1234", nb_rd1, nb_rd2, rd2);
    end
    commit();
    drive(1'b0, '0, '0, AW'(3), '0, 1'b0);
    compared++;
    if (rd1 !== 16'hBEEF || nb_rd1 !== 16'hBEEF) begin
      mismatched++;
      $display("FAIL bypass_after_edge: got %h/%h expected beef", rd1, nb_rd1);
    end
  endtask

  task automatic test_bank_swap();
    drive(1'b1, AW'(7), 16'h00AA, '0, '0, 1'b0);
    commit();
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    commit();
    drive(1'b0, '0, '0, AW'(7), AW'(5), 1'b0);
    compared++;
    if (rd1 !== '0 || rd2 !== '0 || active_bank !== BW'(1)) begin
      mismatched++;
      $display("FAIL swap_to_1: got %h %h bank %0d expected 0 0 bank 1", rd1, rd2, active_bank);
    end
    drive(1'b1, AW'(7), 16'h0055, AW'(7), '0, 1'b0);
    commit();
    drive(1'b0, '0, '0, AW'(7), '0, 1'b0);
    compared++;
    if (rd1 !== 16'h0055) begin
      mismatched++;
      $display("FAIL bank1_r7: got %h expected 0055", rd1);
    end
    drive(1'b0, '0, '0, AW'(7), '0, 1'b1);
    commit();
    drive(1'b0, '0, '0, AW'(7), AW'(3), 1'b0);
    compared++;
    if (rd1 !== 16'h00AA || rd2 !== 16'hBEEF || active_bank !== BW'(0)) begin
      mismatched++;
      $display("FAIL swap_back: got %h %h bank %0d expected 00aa beef bank 0", rd1, rd2, active_bank);
    end
  endtask

  task automatic test_write_with_swap();
    drive(1'b1, AW'(2), 16'h0F0F, AW'(6), '0, 1'b1);
    commit();
    drive(1'b0, '0, '0, AW'(2), '0, 1'b0);
    compared++;
    if (rd1 !== '0 || active_bank !== BW'(1)) begin
      mismatched++;
      $display("FAIL wr_swap_bank1: got %h bank %0d expected 0 bank 1", rd1, active_bank);
    end
    drive(1'b0, '0, '0, AW'(2), '0, 1'b1);
    commit();
    drive(1'b0, '0, '0, AW'(2), '0, 1'b0);
    compared++;
    if (rd1 !== 16'h0F0F || active_bank !== BW'(0)) begin
      mismatched++;
      $display("FAIL wr_swap_bank0: got %h bank %0d expected 0f0f bank 0", rd1, active_bank);
    end
  endtask

  task automatic test_swap_run();
    int start;
    start = model_bank;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, '0, '0, '0, '0, 1'b1);
      commit();
      compared++;
      if (active_bank !== BW'((start + k) % NBANKS) || nb_active_bank !== BW'((start + k) % NBANKS)) begin
        mismatched++;
        $display("FAIL swap_run k=%0d: got %0d/%0d expected %0d", k, active_bank, nb_active_bank, (start + k) % NBANKS);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(1)), AW'($urandom_range(NREGS - 1)), WIDTH'($urandom),
            AW'($urandom_range(NREGS - 1)), AW'($urandom_range(NREGS - 1)),
            1'($urandom_range(3) == 0));
      compared++;
      if (rd1 !== exp_rd(ra1, 1'b1) || rd2 !== exp_rd(ra2, 1'b1) ||
          nb_rd1 !== exp_rd(ra1, 1'b0) || nb_rd2 !== exp_rd(ra2, 1'b0) ||
          active_bank !== BW'(model_bank) || nb_active_bank !== BW'(model_bank)) begin
        mismatched++;
        $display("FAIL random i=%0d: got %h %h %h %h bank %0d expected %h %h %h %h bank %0d", i,
                 rd1, rd2, nb_rd1, nb_rd2, active_bank, exp_rd(ra1, 1'b1), exp_rd(ra2, 1'b1),
                 exp_rd(ra1, 1'b0), exp_rd(ra2, 1'b0), model_bank);
      end
      commit();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, AW'(1), 16'h1111, '0, '0, 1'b1);
    commit();
    drive(1'b1, AW'(1), 16'h1111, '0, '0, 1'b0);
    commit();
    drive(1'b0, '0, '0, AW'(1), '0, 1'b0);
    compared++;
    if (rd1 !== 16'h1111) begin
      mismatched++;
      $display("FAIL preload_r1: got %h expected 1111", rd1);
    end
    #3;
    reset = 1'b1;
    #1;
    compared++;
    if (rd1 !== '0 || nb_rd1 !== '0 || active_bank !== '0 || nb_active_bank !== '0) begin
      mismatched++;
      $display("FAIL async_reset: got %h/%h bank %0d expected 0 bank 0", rd1, nb_rd1, active_bank);
    end
    model_clear();
    drive(1'b1, AW'(1), 16'hABCD, AW'(1), AW'(1), 1'b1);
    @(posedge clk); #1;
    compared++;
    if (rd1 !== '0 || rd2 !== '0 || active_bank !== '0) begin
      mismatched++;
      $display("FAIL reset_wins: got %h %h bank %0d expected 0 0 bank 0", rd1, rd2, active_bank);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, AW'(1), '0, 1'b0);
    reset = 1'b0;
    #1;
    compared++;
    if (rd1 !== '0 || active_bank !== '0) begin
      mismatched++;
      $display("FAIL bank0_cleared: got %h bank %0d expected 0 bank 0", rd1, active_bank);
    end
    drive(1'b0, '0, '0, AW'(1), '0, 1'b1);
    commit();
    drive(1'b0, '0, '0, AW'(1), '0, 1'b0);
    compared++;
    if (rd1 !== '0 || active_bank !== BW'(1)) begin
      mismatched++;
      $display("FAIL bank1_cleared: got %h bank %0d expected 0 bank 1", rd1, active_bank);
    end
  endtask

  initial begin
    test_reset();
    test_write_r0();
    test_bypass();
    test_bank_swap();
    test_write_with_swap();
    test_swap_run();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_regfile_banked

// File: doc/regfile_banked.md
REGFILE_BANKED -- requirements
Module: regfile_banked

Interface
REQ-001 Parameter WIDTH, default 16, data width of every register in bits.
REQ-002 Parameter NREGS, default 16, registers per bank; power of two, at least 2; AW = clog2(NREGS).
REQ-003 Parameter NBANKS, default 2, number of register banks; power of two, at least 1; BW = max(1, clog2(NBANKS)).
REQ-004 Parameter BYPASS, default 1, 1 = write-to-read forwarding in the same cycle, 0 = read returns the stored value.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 we3  input  1  write enable.
REQ-008 wa3  input  AW  write address.
REQ-009 wd3  input  WIDTH  write data.
REQ-010 ra1, ra2  input  AW each  read addresses.
REQ-011 bank_swap  input  1  single-cycle request to advance the active bank.
REQ-012 rd1, rd2  output  WIDTH each  combinational read data.
REQ-013 active_bank  output  BW  currently selected bank, registered.

Function
REQ-014 Reads SHALL be combinational from the active bank: rdN = bank[active_bank][raN].
REQ-015 Address 0 SHALL read as 0 in every bank, regardless of writes or bypass.
REQ-016 A write with we3=1 and wa3!=0 SHALL update bank[active_bank][wa3] at the rising edge; a write to address 0 SHALL be discarded.
REQ-017 With BYPASS=1, we3=1, wa3!=0 and raN==wa3, rdN SHALL equal wd3 in the same cycle.
REQ-018 With BYPASS=0, rdN SHALL show the old value until the edge that commits the write.
REQ-019 bank_swap=1 at a rising edge SHALL set active_bank to (active_bank+1) mod NBANKS; 0 SHALL hold it.
REQ-020 With NBANKS=1, bank_swap SHALL be ignored and active_bank SHALL stay 0.
REQ-021 A write and a bank_swap at the same edge SHALL write to the bank that was active before the swap.
REQ-022 Bypass SHALL apply only to the bank active in the current cycle; reads after a swap SHALL return the new bank's stored contents.
REQ-023 A bank_swap held high for k edges SHALL advance the bank k times, wrapping from NBANKS-1 to 0.
REQ-024 Inactive banks SHALL keep their contents unchanged indefinitely.
REQ-025 Read and write latency: 0 cycles for reads and 1 edge for writes; there is no stall and no handshake.

Reset
REQ-026 Asserting reset SHALL immediately clear every register in every bank to 0 and set active_bank to 0, without waiting for a clock edge.
REQ-027 While reset is high, writes and bank_swap SHALL be ignored, and rd1 and rd2 SHALL read 0 for all addresses, including under bypass.
REQ-028 Reset asserted in the same cycle as a write SHALL win; the write SHALL be lost.
REQ-029 The block SHALL not depend on file-based register initialisation.

Structure
REQ-030 Package regfile_pkg SHALL hold the default constants RF_WIDTH=16, RF_NREGS=16 and RF_NBANKS=2.
REQ-031 One sub-module, regfile_bank, SHALL contain a single bank with asynchronous clear, one write port and two combinational read ports.
REQ-032 regfile_banked SHALL instantiate NBANKS copies of regfile_bank and add the bank-select counter, write steering, read muxing and bypass logic.

Verification
REQ-033 Reset, then read all addresses -> every rd1/rd2 is 0 and active_bank is 0.
REQ-034 Write 0x1234 to r5, then r0 <- 0xFFFF, with ra1=5 and ra2=0 -> rd1=0x1234 and rd2=0.
REQ-035 BYPASS=1: we3=1, wa3=3, wd3=0xBEEF, ra1=3 in the same cycle -> rd1=0xBEEF before the edge; with BYPASS=0 -> rd1 shows the old value (0) until after the edge.
REQ-036 Write r7=0x00AA in bank 0; pulse bank_swap; read r7 -> 0, active_bank=1; write r7=0x0055; swap -> r7 reads 0x00AA, active_bank=0.
REQ-037 Write r2=0x0F0F together with bank_swap at the same edge -> bank 0 r2=0x0F0F, bank 1 r2=0, active_bank=1.
REQ-038 Assert reset asynchronously mid-cycle after loading r1=0x1111 in both banks -> rd1 is 0 at once, active_bank=0, and both banks read 0 after release.
